// File: rtl/fft_corner_turn_pkg.sv
// fft_corner_turn_pkg
//   Shared types for the 2-D FFT corner-turn slice.
//   - FXP_W           : width of each real/imaginary component
//   - complex_fxp_t   : packed complex sample {r, i}
//   - ct_bank_state_e : life cycle of one ping-pong bank
//   - bitrev()        : reverses the low nbits of an index. The corner turn uses it
//                       when FFT_CT_BITREV_EN is defined.
package fft_corner_turn_pkg;

  localparam int FXP_W = 16;

  typedef struct packed {
    logic signed [FXP_W-1:0] r;
    logic signed [FXP_W-1:0] i;
  } complex_fxp_t;

  // A bank is filled row-wise by the write side and drained column-wise by the
  // read side. The two sides never own the same bank at the same time.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } ct_bank_state_e;

  // Mirror the low nbits of idx. Bit b moves to position nbits-1-b.
  function automatic int bitrev(input int idx, input int nbits);
    int res;
    res = 0;
    for (int b = 0; b < nbits; b++) begin
      res = res | (((idx >> b) & 1) << (nbits - 1 - b));
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_corner_turn_if.sv
// fft_corner_turn_if
//   Streaming bus of the corner turn. It carries both the row-beat input side
//   and the column-beat output side.
//   in[l][c]  / valid_in / ready_in   : row beat in, accepted on valid_in & ready_in
//   out[l][r] / valid_out / ready_out : column beat out, consumed on valid_out & ready_out
//   tile_last                         : marks the final output beat of a tile
//   Modport roles:
//   - master : the environment. It drives in, valid_in and ready_out.
//   - slave  : the corner turn itself.
interface fft_corner_turn_if #(
  parameter int N     = 16,
  parameter int LANES = 2
);

  fft_corner_turn_pkg::complex_fxp_t [LANES-1:0][N-1:0] in;
  logic                                                 valid_in;
  logic                                                 ready_in;
  fft_corner_turn_pkg::complex_fxp_t [LANES-1:0][N-1:0] out;
  logic                                                 valid_out;
  logic                                                 ready_out;
  logic                                                 tile_last;

  modport master (
    output in, valid_in, ready_out,
    input  ready_in, out, valid_out, tile_last
  );

  modport slave (
    input  in, valid_in, ready_out,
    output ready_in, out, valid_out, tile_last
  );

endinterface

// File: rtl/fft_corner_turn_bank_ctrl.sv
// ct_bank_ctrl
//   Bookkeeping for one side of the ping-pong buffer (write side or read side).
//   It holds the beat counter and the bank pointer. It also reports the state
//   that the bank it points at should take when a beat is transferred.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     fire        : a beat is transferred on this side at the next edge
//     bank        : bank currently owned by this side
//     beat        : beat index within the current tile
//     last_beat   : beat is the final beat of the tile
//     next_state  : state to write into bank[bank] when fire is high
//   FILL_SIDE = 1 selects the write-side transitions (FILLING/FULL).
//   FILL_SIDE = 0 selects the read-side transitions (DRAINING/EMPTY).
module ct_bank_ctrl
  import fft_corner_turn_pkg::*;
#(
  parameter int BEATS     = 8,
  parameter int BW        = 3,
  parameter bit FILL_SIDE = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           fire,
  output logic           bank,
  output logic [BW-1:0]  beat,
  output logic           last_beat,
  output ct_bank_state_e next_state
);

  assign last_beat = (beat == BW'(BEATS - 1));

  // Advance one beat per transfer. The final beat of a tile wraps the counter
  // and hands this side over to the other bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank <= 1'b0;
      beat <= '0;
    end else if (fire) begin
      if (last_beat) begin
        bank <= ~bank;
        beat <= '0;
      end else begin
        beat <= beat + BW'(1);
      end
    end
  end

  // The write side marks a bank busy on its first beat and complete on its last.
  // The read side releases the bank only after its final column has gone out.
  always_comb begin
    next_state = EMPTY;
    if (FILL_SIDE) begin
      next_state = last_beat ? FULL : FILLING;
    end else begin
      next_state = last_beat ? EMPTY : DRAINING;
    end
  end

endmodule

// File: rtl/fft_corner_turn.sv
// fft_corner_turn
//   Double-buffered corner turn (transpose) between the row and column 1-D FFT
//   stages. An N x N complex tile arrives as LANES rows per beat and leaves as
//   LANES columns per beat. Two banks ping-pong, so back-to-back tiles stream at
//   one beat per cycle on both sides.
//   Ports:
//     clk    : clock
//     reset  : asynchronous reset, active high. Clears the banks and all
//              bookkeeping.
//     bus    : fft_corner_turn_if.slave. Carries:
//              - in / valid_in / ready_in
//              - out / valid_out / ready_out
//              - tile_last
//   Build option:
//     FFT_CT_BITREV_EN : when defined, the column index and the row index of each
//                        output column are bit-reversed. This undoes radix-2
//                        output ordering. Handshake and latency are unchanged.
module fft_corner_turn
  import fft_corner_turn_pkg::*;
#(
  parameter int N     = 16,
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             reset,
  fft_corner_turn_if.slave bus
);

  localparam int BEATS = N / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LOG2N = $clog2(N);
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  complex_fxp_t   mem [2][N][N];
  ct_bank_state_e bank_state [2];

  logic           wr_bank, rd_bank;
  logic [BW-1:0]  wr_beat, rd_beat;
  logic           wr_last, rd_last;
  ct_bank_state_e wr_next, rd_next;
  logic           wr_fire, rd_fire;
  logic [LOG2N-1:0] wr_row_base;

  // Output ordering of one index: natural, or bit-reversed across log2(N) bits.
  function automatic logic [LOG2N-1:0] order(input int idx);
`ifdef FFT_CT_BITREV_EN
    return LOG2N'(bitrev(idx, LOG2N));
`else
    return LOG2N'(idx);
`endif
  endfunction

  // Handshakes decode only the registered bank states.
  // A write can target only an EMPTY or FILLING bank.
  // A read can target only a FULL or DRAINING bank.
  // Therefore the two sides can never land on the same bank at once.
  assign bus.ready_in  = (bank_state[wr_bank] == EMPTY) || (bank_state[wr_bank] == FILLING);
  assign bus.valid_out = (bank_state[rd_bank] == FULL)  || (bank_state[rd_bank] == DRAINING);
  assign bus.tile_last = bus.valid_out && rd_last;

  assign wr_fire     = bus.valid_in && bus.ready_in;
  assign rd_fire     = bus.valid_out && bus.ready_out;
  assign wr_row_base = LOG2N'(int'(wr_beat) * LANES);

  ct_bank_ctrl #(
    .BEATS     (BEATS),
    .BW        (BW),
    .FILL_SIDE (1'b1)
  ) u_wr_ctrl (
    .clk        (clk),
    .reset      (reset),
    .fire       (wr_fire),
    .bank       (wr_bank),
    .beat       (wr_beat),
    .last_beat  (wr_last),
    .next_state (wr_next)
  );

  ct_bank_ctrl #(
    .BEATS     (BEATS),
    .BW        (BW),
    .FILL_SIDE (1'b0)
  ) u_rd_ctrl (
    .clk        (clk),
    .reset      (reset),
    .fire       (rd_fire),
    .bank       (rd_bank),
    .beat       (rd_beat),
    .last_beat  (rd_last),
    .next_state (rd_next)
  );

  // Bank life cycle. Each side updates only the bank it owns. Because of the
  // ready/valid decode above, the two updates always hit different entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        bank_state[b] <= EMPTY;
      end
    end else begin
      if (wr_fire) begin
        bank_state[wr_bank] <= wr_next;
      end
      if (rd_fire) begin
        bank_state[rd_bank] <= rd_next;
      end
    end
  end

  // Row-wise fill. Lane l of an accepted beat lands in row wr_beat*LANES+l of
  // the write bank. Reset zeroes both banks, so an idle output reads as 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            mem[b][LOG2N'(r)][LOG2N'(c)] <= '0;
          end
        end
      end
    end else if (wr_fire) begin
      for (int l = 0; l < LANES; l++) begin
        for (int c = 0; c < N; c++) begin
          mem[wr_bank][wr_row_base + LOG2N'(l)][LOG2N'(c)] <= bus.in[LW'(l)][LOG2N'(c)];
        end
      end
    end
  end

  // Column-wise read. The mux is purely combinational from registered state.
  // While ready_out is low nothing moves, so out holds its value.
  always_comb begin
    bus.out = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int r = 0; r < N; r++) begin
        bus.out[LW'(l)][LOG2N'(r)] = mem[rd_bank][order(r)][order(int'(rd_beat) * LANES + l)];
      end
    end
  end

endmodule

// File: tb/tb_fft_corner_turn.sv
// tb_fft_corner_turn
//   Self-checking bench for fft_corner_turn (N=16, LANES=2).
//   The scoreboard keeps whole tiles as the bench accepted them. It predicts
//   every output beat as a transpose of the front tile. The index order is
//   natural, or bit-reversed when FFT_CT_BITREV_EN is defined.
//   Directed sequences cover the following:
//   - reset values
//   - first-tile latency
//   - full-rate back-to-back tiles
//   - back-pressure stall
//   - toggled ready_out
//   - reset in the middle of a tile
`timescale 1ns/1ps
module tb_fft_corner_turn;
  import fft_corner_turn_pkg::*;

  localparam int N     = 16;
  localparam int LANES = 2;
  localparam int BEATS = N / LANES;

  typedef complex_fxp_t [LANES-1:0][N-1:0] beat_t;
  typedef complex_fxp_t [N-1:0][N-1:0]     tile_t;

  typedef struct {
    int beat;
    int lane;
    int row;
    int exp_re;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int check_cnt   = 0;
  int pass_cnt    = 0;
  int last_pulses = 0;

  tile_t sb_q[$];
  tile_t acc;
  beat_t mon_exp;
  int    wr_k = 0;
  int    rd_k = 0;

  fft_corner_turn_if #(.N(N), .LANES(LANES)) bus ();

  fft_corner_turn #(.N(N), .LANES(LANES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Index order expected at the output.
  function automatic int ref_idx(input int idx);
`ifdef FFT_CT_BITREV_EN
    int res;
    res = 0;
    for (int b = 0; b < $clog2(N); b++) begin
      if (((idx >> b) & 1) != 0) res = res + (1 << ($clog2(N) - 1 - b));
    end
    return res;
`else
    return idx;
`endif
  endfunction

  function automatic tile_t make_pattern(input int base);
    tile_t t;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        t[r][c].r = 16'(base + N * r + c);
        t[r][c].i = 16'(-(base + N * r + c));
      end
    end
    return t;
  endfunction

  function automatic tile_t make_random();
    tile_t t;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        t[r][c] = complex_fxp_t'($urandom);
      end
    end
    return t;
  endfunction

  function automatic beat_t in_beat(input tile_t t, input int k);
    beat_t b;
    for (int l = 0; l < LANES; l++) begin
      for (int c = 0; c < N; c++) begin
        b[l][c] = t[k * LANES + l][c];
      end
    end
    return b;
  endfunction

  // Output beat k is the transpose: lane l carries column k*LANES+l, indexed by row.
  function automatic beat_t exp_beat(input tile_t t, input int k);
    beat_t e;
    for (int l = 0; l < LANES; l++) begin
      for (int r = 0; r < N; r++) begin
        e[l][r] = t[ref_idx(r)][ref_idx(k * LANES + l)];
      end
    end
    return e;
  endfunction

  task automatic check_output(input string name, input logic ok, input longint act, input longint exp);
    check_cnt++;
    if (ok) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Compare the whole output beat. On a mismatch, report the first bad element.
  task automatic compare_beat(input string name, input beat_t e);
    int sl, sr;
    logic ok;
    sl = 0;
    sr = 0;
    ok = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      for (int r = 0; r < N; r++) begin
        if (ok && (bus.out[l][r] !== e[l][r])) begin
          ok = 1'b0;
          sl = l;
          sr = r;
        end
      end
    end
    check_output($sformatf("%s[%0d][%0d]", name, sl, sr), ok,
                 longint'(bus.out[sl][sr]), longint'(e[sl][sr]));
  endtask

  task automatic apply_stimulus(input logic v, input beat_t b, input logic ro);
    @(posedge clk);
    #1;
    bus.valid_in  = v;
    bus.in        = b;
    bus.ready_out = ro;
  endtask

  // Scoreboard. It samples at the falling edge, where the handshakes for the
  // coming rising edge are settled. The output is checked before new input is
  // recorded: a tile cannot be read in the same cycle its last row arrives.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      wr_k = 0;
      rd_k = 0;
    end else begin
      if (bus.valid_out) begin
        if (sb_q.size() == 0) begin
          check_output("spurious_valid", 1'b0, 1, 0);
        end else begin
          mon_exp = exp_beat(sb_q[0], rd_k);
          compare_beat("stream_beat", mon_exp);
          check_output("stream_last", bus.tile_last == (rd_k == BEATS - 1),
                       bus.tile_last, (rd_k == BEATS - 1));
          if (bus.ready_out) begin
            if (bus.tile_last) last_pulses++;
            rd_k++;
            if (rd_k == BEATS) begin
              rd_k = 0;
              void'(sb_q.pop_front());
            end
          end
        end
      end else begin
        check_output("idle_last", bus.tile_last == 1'b0, bus.tile_last, 0);
      end
      if (bus.valid_in && bus.ready_in) begin
        for (int l = 0; l < LANES; l++) acc[wr_k * LANES + l] = bus.in[l];
        wr_k++;
        if (wr_k == BEATS) begin
          wr_k = 0;
          sb_q.push_back(acc);
        end
      end
    end
  end

  // Stream ntiles tiles under a ready_out pattern and return handshake statistics.
  // The task stops when all tiles are written and the scoreboard has drained.
  // Modes:
  //   0 : pattern data, ready_out held high
  //   1 : random data, ready_out low for 30 cycles
  //   2 : random data, ready_out toggling 1010
  //   3 : random data, ready_out held high
  task automatic stream(input int ntiles, input int mode, output int stall_beats,
                        output int ready_low, output int consumed, output int span);
    tile_t tiles [4];
    int    ti, k, cyc, accepted, first_c, last_c, budget;
    logic  ro;
    ti = 0; k = 0; cyc = 0; accepted = 0; first_c = -1; last_c = -1;
    budget = ntiles * BEATS * 4 + 64;
    stall_beats = -1; ready_low = 0; consumed = 0;
    for (int t = 0; t < ntiles; t++) tiles[t] = (mode == 0) ? make_pattern(256 * t) : make_random();
    while (cyc < budget) begin
      ro = (mode == 1) ? (cyc >= 30) : (mode == 2) ? ((cyc % 2) == 0) : 1'b1;
      apply_stimulus(ti < ntiles, (ti < ntiles) ? in_beat(tiles[ti], k) : '0, ro);
      if (ti == ntiles && sb_q.size() == 0) break;
      @(negedge clk);
      if (bus.valid_in && !bus.ready_in) begin
        ready_low++;
        if (stall_beats < 0) stall_beats = accepted;
      end
      if (bus.valid_in && bus.ready_in) begin
        accepted++;
        k++;
        if (k == BEATS) begin
          k = 0;
          ti++;
        end
      end
      if (bus.valid_out && bus.ready_out) begin
        consumed++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      cyc++;
    end
    check_output("stream_timeout", cyc < budget, cyc, budget);
    span = last_c - first_c + 1;
    bus.valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t  vecs [6];
    tile_t t_a, t_b;
    int    stall_beats, ready_low, consumed, span, pulses0;

`ifdef FFT_CT_BITREV_EN
    vecs[0] = '{0, 0, 0, 0};
    vecs[1] = '{0, 0, 1, 128};
    vecs[2] = '{0, 1, 0, 8};
    vecs[3] = '{3, 1, 5, 174};
    vecs[4] = '{7, 1, 15, 255};
    vecs[5] = '{7, 0, 0, 7};
`else
    vecs[0] = '{0, 0, 0, 0};
    vecs[1] = '{0, 0, 1, 16};
    vecs[2] = '{0, 1, 0, 1};
    vecs[3] = '{3, 1, 5, 87};
    vecs[4] = '{7, 1, 15, 255};
    vecs[5] = '{7, 0, 0, 14};
`endif

    bus.valid_in  = 1'b0;
    bus.in        = '0;
    bus.ready_out = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("rst_ready_in", bus.ready_in === 1'b1, bus.ready_in, 1);
    check_output("rst_valid_out", bus.valid_out === 1'b0, bus.valid_out, 0);
    check_output("rst_tile_last", bus.tile_last === 1'b0, bus.tile_last, 0);
    check_output("rst_out_zero", bus.out === '0, (bus.out !== '0), 0);

    // Single tile: no output until the last row is in, then 8 column beats.
    $display("[TB] single tile latency and transpose");
    t_a = make_pattern(0);
    for (int k = 0; k < BEATS; k++) begin
      apply_stimulus(1'b1, in_beat(t_a, k), 1'b1);
      @(negedge clk);
      check_output("t1_no_early_valid", bus.valid_out === 1'b0, bus.valid_out, 0);
    end
    for (int k = 0; k < BEATS; k++) begin
      apply_stimulus(1'b0, '0, 1'b1);
      @(negedge clk);
      check_output("t1_valid", bus.valid_out === 1'b1, bus.valid_out, 1);
      check_output("t1_tile_last", bus.tile_last == (k == BEATS - 1), bus.tile_last, (k == BEATS - 1));
      for (int i = 0; i < 6; i++) begin
        if (vecs[i].beat == k) begin
          check_output($sformatf("t1_re[%0d]", i),
                       bus.out[vecs[i].lane][vecs[i].row].r == 16'(vecs[i].exp_re),
                       bus.out[vecs[i].lane][vecs[i].row].r, vecs[i].exp_re);
          check_output($sformatf("t1_im[%0d]", i),
                       bus.out[vecs[i].lane][vecs[i].row].i == 16'(-vecs[i].exp_re),
                       bus.out[vecs[i].lane][vecs[i].row].i, -vecs[i].exp_re);
        end
      end
    end
    apply_stimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    check_output("t1_valid_drop", bus.valid_out === 1'b0, bus.valid_out, 0);

    $display("[TB] four back-to-back tiles at full rate");
    stream(4, 0, stall_beats, ready_low, consumed, span);
    check_output("t2_ready_never_low", ready_low == 0, ready_low, 0);
    check_output("t2_consumed", consumed == 4 * BEATS, consumed, 4 * BEATS);
    check_output("t2_contiguous", span == 4 * BEATS, span, 4 * BEATS);

    $display("[TB] back-pressure with both banks full");
    stream(3, 1, stall_beats, ready_low, consumed, span);
    check_output("t3_stall_point", stall_beats == 2 * BEATS, stall_beats, 2 * BEATS);
    check_output("t3_consumed", consumed == 3 * BEATS, consumed, 3 * BEATS);

    $display("[TB] toggled ready_out during drain");
    pulses0 = last_pulses;
    stream(2, 2, stall_beats, ready_low, consumed, span);
    check_output("t4_consumed", consumed == 2 * BEATS, consumed, 2 * BEATS);
    check_output("t4_last_pulses", (last_pulses - pulses0) == 2, last_pulses - pulses0, 2);

    // Reset with one bank draining and the other half filled.
    $display("[TB] reset during fill and drain");
    t_a = make_random();
    t_b = make_random();
    for (int k = 0; k < BEATS; k++) begin
      apply_stimulus(1'b1, in_beat(t_a, k), 1'b0);
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1, in_beat(t_b, k), 1'b1);
      @(negedge clk);
      check_output("t5_ready_in", bus.ready_in === 1'b1, bus.ready_in, 1);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.valid_in = 1'b0;
    @(negedge clk);
    check_output("t5_valid_out", bus.valid_out === 1'b0, bus.valid_out, 0);
    check_output("t5_ready_in_rst", bus.ready_in === 1'b1, bus.ready_in, 1);
    check_output("t5_out_zero", bus.out === '0, (bus.out !== '0), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    stream(1, 3, stall_beats, ready_low, consumed, span);
    check_output("t5_fresh_consumed", consumed == BEATS, consumed, BEATS);

    check_output("model_drained", sb_q.size() == 0, sb_q.size(), 0);
    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
